// File: rtl/fb_kbd_fifo_stat.sv
// Buffered keyboard scan-code FIFO with a 32-bit status word and a pop-on-read data word.
// Optional interrupt output is enabled by defining FB_KBD_IRQ_EN.
module fb_kbd_fifo_stat #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              av,
  input  logic [DATA_W-1:0] scan_code,
  input  logic              rd_data_en,
  input  logic              clr,
  output logic [31:0]       status,
  output logic [31:0]       data,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overrun_reg, overrun_next;
  logic          underflow_reg, underflow_next;

  logic          empty, full, valid;
  logic          do_push, do_pop;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DATA_W-1:0] head;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign valid = ~empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overrun_next   = overrun_reg;
    underflow_next = underflow_reg;
    do_push        = 1'b0;
    do_pop         = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_ptr_reg;
    if (clr) begin
      // Clear wins over the CPU read, but an arriving code is still captured at entry 0.
      rd_ptr_next    = '0;
      overrun_next   = 1'b0;
      underflow_next = 1'b0;
      mem_we         = av;
      mem_waddr      = '0;
      wr_ptr_next    = av ? AW'(1) : '0;
      count_next     = av ? CW'(1) : '0;
    end else begin
      do_pop  = rd_data_en & ~empty;
      do_push = av & (~full | do_pop);
      mem_we  = do_push;
      if (rd_data_en && empty) underflow_next = 1'b1;
      if (av && !do_push)      overrun_next   = 1'b1;
      if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overrun_reg   <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overrun_reg   <= overrun_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is not reset; count gates every read so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= scan_code;
  end

  assign head = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_data
      if (gi < DATA_W) begin : g_bit
        assign data[gi] = valid & head[gi];
      end else begin : g_pad
        assign data[gi] = 1'b0;
      end
    end
  endgenerate

  assign status = {16'b0, 8'(count_reg), 4'b0, underflow_reg, overrun_reg, full, valid};

`ifdef FB_KBD_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= valid | overrun_reg;
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fb_kbd_fifo_stat.sv
// Table-driven bench for fb_kbd_fifo_stat (DEPTH=8, DATA_W=8) plus an async-reset sequence.
module tb_fb_kbd_fifo_stat;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        av = 1'b0;
  logic [7:0]  scan_code = '0;
  logic        rd_data_en = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] status, data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  fb_kbd_fifo_stat #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .av(av), .scan_code(scan_code),
    .rd_data_en(rd_data_en), .clr(clr),
    .status(status), .data(data), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [7:0]  code;
    logic        rd;
    logic        clr;
    logic [31:0] st;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic [7:0] c, input logic r, input logic cl,
                     input logic [31:0] s, input logic [31:0] d);
    vec_t v;
    v.av = a; v.code = c; v.rd = r; v.clr = cl; v.st = s; v.dat = d;
    vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h exp %h", name, idx, got, exp);
    end
  endtask

  task automatic chk1(input string name, input int idx, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %b exp %b", name, idx, got, exp);
    end
  endtask

  function automatic logic exp_irq_from(input logic [31:0] prev_st);
`ifdef FB_KBD_IRQ_EN
    return prev_st[0] | prev_st[2];
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] prev_st;

  initial begin
    // Basic push/pop, underflow, clr and clr+av
    add(1, 8'h1C, 0, 0, 32'h101, 32'h1C);
    add(1, 8'h32, 0, 0, 32'h201, 32'h1C);
    add(1, 8'h21, 0, 0, 32'h301, 32'h1C);
    add(0, 8'h00, 1, 0, 32'h201, 32'h32);
    add(0, 8'h00, 1, 0, 32'h101, 32'h21);
    add(0, 8'h00, 1, 0, 32'h000, 32'h00);
    add(0, 8'h00, 1, 0, 32'h008, 32'h00);
    add(0, 8'h00, 0, 1, 32'h000, 32'h00);
    add(1, 8'h5A, 0, 1, 32'h101, 32'h5A);
    add(0, 8'h00, 1, 1, 32'h000, 32'h00);
    // Fill to full, then overrun on the 9th push
    for (int i = 1; i <= 7; i++) add(1, 8'(i), 0, 0, (32'(i) << 8) | 32'h1, 32'h01);
    add(1, 8'h08, 0, 0, 32'h803, 32'h01);
    add(1, 8'h09, 0, 0, 32'h807, 32'h01);
    // Drain: 9th code must not appear
    for (int i = 1; i <= 7; i++) add(0, 8'h00, 1, 0, (32'(8 - i) << 8) | 32'h5, 32'(i + 1));
    add(0, 8'h00, 1, 0, 32'h004, 32'h00);
    add(0, 8'h00, 0, 1, 32'h000, 32'h00);
    // Full with simultaneous push+pop: no overrun, new code last out
    for (int i = 1; i <= 7; i++) add(1, 8'(8'h10 + i), 0, 0, (32'(i) << 8) | 32'h1, 32'h11);
    add(1, 8'h18, 0, 0, 32'h803, 32'h11);
    add(1, 8'h19, 1, 0, 32'h803, 32'h12);
    for (int i = 1; i <= 7; i++) add(0, 8'h00, 1, 0, (32'(8 - i) << 8) | 32'h1, 32'(8'h12 + i));
    add(0, 8'h00, 1, 0, 32'h000, 32'h00);
    // Push+pop on empty: underflow and push both happen
    add(1, 8'h20, 1, 0, 32'h109, 32'h20);
    add(0, 8'h00, 0, 1, 32'h000, 32'h00);
    // Wrap: 10 codes with interleaved pops, order preserved
    for (int i = 0; i < 6; i++) add(1, 8'(8'hA0 + i), 0, 0, (32'(i + 1) << 8) | 32'h1, 32'hA0);
    for (int i = 0; i < 4; i++) add(1, 8'(8'hA6 + i), 1, 0, 32'h601, 32'(8'hA1 + i));
    for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 0, (32'(5 - i) << 8) | 32'h1, 32'(8'hA5 + i));
    add(0, 8'h00, 1, 0, 32'h000, 32'h00);

    // Reset state
    repeat (2) @(negedge clk);
    chk32("reset_status", -1, status, 32'h0);
    chk32("reset_data", -1, data, 32'h0);
    chk1("reset_irq", -1, irq, 1'b0);
    rst = 1'b0;
    prev_st = 32'h0;

    foreach (vecs[i]) begin
      av = vecs[i].av; scan_code = vecs[i].code; rd_data_en = vecs[i].rd; clr = vecs[i].clr;
      @(negedge clk);
      $display("vec %0d av=%b code=%h rd=%b clr=%b -> status=%h data=%h irq=%b",
               i, vecs[i].av, vecs[i].code, vecs[i].rd, vecs[i].clr, status, data, irq);
      chk32("status", i, status, vecs[i].st);
      chk32("data", i, data, vecs[i].dat);
      chk1("irq", i, irq, exp_irq_from(prev_st));
      prev_st = vecs[i].st;
    end
    av = 1'b0; rd_data_en = 1'b0; clr = 1'b0;

    // Async reset mid-stream
    av = 1'b1; scan_code = 8'h33;
    @(negedge clk);
    scan_code = 8'h44;
    @(negedge clk);
    av = 1'b0;
    chk32("pre_rst_status", 100, status, 32'h201);
    #2 rst = 1'b1;
    #1;
    $display("async rst -> status=%h data=%h irq=%b", status, data, irq);
    chk32("async_rst_status", 101, status, 32'h0);
    chk32("async_rst_data", 101, data, 32'h0);
    chk1("async_rst_irq", 101, irq, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk32("post_rst_idle", 102, status, 32'h0);
    av = 1'b1; scan_code = 8'h55;
    @(negedge clk);
    av = 1'b0;
    $display("post-rst push 55 -> status=%h data=%h irq=%b", status, data, irq);
    chk32("post_rst_status", 103, status, 32'h101);
    chk32("post_rst_data", 103, data, 32'h55);
    chk1("irq_lag_rise", 103, irq, 1'b0);
    rd_data_en = 1'b1;
    @(negedge clk);
    rd_data_en = 1'b0;
    $display("pop -> status=%h data=%h irq=%b", status, data, irq);
    chk32("final_pop_status", 104, status, 32'h0);
    chk1("irq_after_push", 104, irq, exp_irq_from(32'h101));
    @(negedge clk);
    chk1("irq_after_drain", 105, irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
